// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
// Round-robin, packet-locked arbiter for one output link of the mesh router.
// One input owns the link from its grant until its end-of-packet beat. A beat
// that reaches MAX_BEATS without eop is sent with eop forced on, so a runaway
// packet cannot hold the link forever. Beats go through a one-deep output
// register that uses valid/ready flow control.
//
// Ports:
//   clk, rst             rising-edge clock; asynchronous active-low reset
//   req_valid/req_packet one beat per input, input i in [i*PKT_W +: PKT_W]
//   req_ready            per-input accept strobe; only the owner can be ready
//   out_valid/out_packet output register contents
//   out_ready            downstream accepts out_packet
//   grant_id             current owner; meaningful only while busy=1
//   busy                 high while a packet holds the link
//   len_err              one-cycle pulse after a forced release
module noc_output_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int PKT_W     = 14,
  parameter int MAX_BEATS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN-1:0]           req_valid,
  input  logic [NUM_IN*PKT_W-1:0]     req_packet,
  output logic [NUM_IN-1:0]           req_ready,
  output logic                        out_valid,
  output logic [PKT_W-1:0]            out_packet,
  input  logic                        out_ready,
  output logic [$clog2(NUM_IN)-1:0]   grant_id,
  output logic                        busy,
  output logic                        len_err
);

  localparam int IDW   = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [PKT_W-1:0]   out_packet_q, out_packet_d;
  logic               len_err_q, len_err_d;

  logic [PKT_W-1:0]   pkt_arr [NUM_IN];
  logic [IDW-1:0]     pick_id;
  logic [PKT_W-1:0]   owner_beat;
  logic               accept;
  logic               forced;

  // Split the flat request bus into one beat per input.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign pkt_arr[gi] = req_packet[gi*PKT_W +: PKT_W];
  end

  // Round-robin search from rr_ptr upwards (mod NUM_IN). The loop runs from
  // the farthest offset down, so the nearest requester is the last one
  // assigned and wins.
  always_comb begin
    logic [IDW-1:0] idx;
    pick_id = '0;
    idx     = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = rr_ptr_q + IDW'(k);
      if (req_valid[idx]) pick_id = idx;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_packet_q <= out_packet_d;
      len_err_q    <= len_err_d;
    end
  end

  // Output decode. req_ready depends only on state, the output register and
  // out_ready. It never depends on req_valid, which avoids a combinational
  // loop through an upstream source that waits for ready.
  always_comb begin
    req_ready = '0;
    busy      = (state_q == LOCKED);
    if (state_q == LOCKED) begin
      req_ready[grant_id_q] = !out_valid_q || out_ready;
    end
  end

  assign owner_beat = pkt_arr[grant_id_q];
  assign accept     = (state_q == LOCKED) && req_valid[grant_id_q] && req_ready[grant_id_q];
  assign forced     = accept && !owner_beat[0] && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_packet_d = out_packet_q;
    len_err_d    = 1'b0;

    // The output register keeps draining in IDLE after the last beat.
    if (accept) begin
      out_valid_d  = 1'b1;
      out_packet_d = owner_beat;
      if (forced) out_packet_d[0] = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d    = LOCKED;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          if (owner_beat[0] || forced) begin
            // Release the link. The input that just finished now has the
            // lowest priority.
            state_d    = IDLE;
            rr_ptr_d   = grant_id_q + 1'b1;
            beat_cnt_d = '0;
            len_err_d  = forced;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid  = out_valid_q;
  assign out_packet = out_packet_q;
  assign grant_id   = grant_id_q;
  assign len_err    = len_err_q;

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
Round-robin, packet-locked arbiter for one output link of the 2x2 mesh router. It shares that link between the four input ports whose decoded dst_addr targets it. It grants one input at a time and holds the grant until that input's end-of-packet beat, so beats of different packets never interleave. It forwards beats through a one-deep output register with valid/ready flow control and enforces a maximum packet length.

Parameters:
NUM_IN, 4, number of requesting input ports (power of two, ≥2)
PKT_W, 14, packet width: [12:11] dst_addr, [10:9] pack_t, [8:1] payload, [0] eop
MAX_BEATS, 8, maximum beats per packet before forced release (≥1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NUM_IN  input i presents a beat for this output
req_packet  input  NUM_IN*PKT_W  beat of input i, in bits [i*PKT_W +: PKT_W]
req_ready  output  NUM_IN  beat of input i accepted this cycle
out_valid  output  1  output register holds a beat
out_packet  output  PKT_W  beat to downstream link
out_ready  input  1  downstream accepts out_packet
grant_id  output  $clog2(NUM_IN)  current owner; meaningful only when busy=1
busy  output  1  FSM is in LOCKED
len_err  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=0, asynchronous) drives the block to this state: FSM=IDLE, rr_ptr=0, beat_cnt=0, out_valid=0, out_packet=0, grant_id=0, busy=0, len_err=0. req_ready=0 while in IDLE.
- A reset asserted mid-packet drops the in-flight beat and the lock. The upstream input port re-sends the packet.
- FSM IDLE:
  - If any req_valid is set, pick the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_IN.
  - Next cycle: LOCKED, grant_id=i, beat_cnt=0.
  - No beat is accepted in IDLE (one arbitration bubble).
- FSM LOCKED:
  - req_ready[grant_id] = (!out_valid || out_ready). All other req_ready are 0.
  - req_ready is combinational from out_ready. There is no combinational path from req_valid to req_ready.
  - Accept = req_valid[grant_id] && req_ready[grant_id].
  - On accept: out_packet <= beat, out_valid <= 1, beat_cnt <= beat_cnt+1.
  - If out_ready=1 and there is no accept: out_valid <= 0.
  - Accepted beat with eop=1: FSM→IDLE, rr_ptr <= (grant_id+1) mod NUM_IN, beat_cnt <= 0.
  - Accepted beat with eop=0 and beat_cnt==MAX_BEATS-1 (forced release):
    - beat is forwarded with bit[0] forced to 1;
    - len_err=1 for exactly the next cycle;
    - FSM→IDLE and rr_ptr advances exactly as for a normal eop.
  - Requests from non-owners are ignored while LOCKED. Their req_valid may stay high indefinitely.
  - An owner deasserting req_valid mid-packet holds the lock. There is no timeout.
- Latency: req_valid rising in IDLE → out_valid=1 two cycles later, given out_ready=1. Subsequent beats stream at 1 beat/cycle. Between packets there is a 1-cycle bubble (the IDLE cycle).
- Output register:
  - out_packet is stable while out_valid=1 && out_ready=0.
  - A simultaneous drain (out_ready) and load (accept) in the same cycle yields out_valid=1 with the new beat.
  - After the final beat the register still drains in IDLE. No new accept occurs until the next LOCKED cycle.
- Fairness: after releasing input k, input k has the lowest priority. Any continuously requesting input is granted within NUM_IN-1 packets.
- Payload, dst_addr and pack_t pass through unmodified. The only exception is eop on a forced release.
- busy=1 exactly while in LOCKED. grant_id holds its last value while in IDLE.

Test Plan:
1. Single packet: reset, then input 2 sends beats 0x0D4A, 0x0D4A, 0x0D4B (dst=01, type=10, payload=A5, last has eop) with out_ready=1 → out_valid rises 2 cycles after req_valid; out_packet = 0x0D4A, 0x0D4A, 0x0D4B on consecutive cycles; busy drops after the eop accept; rr_ptr=3.
2. Round-robin: all 4 inputs continuously send 2-beat packets → grant order 0,1,2,3,0,…; no interleaving; exactly one idle cycle between packets.
3. Backpressure: out_ready=0 for 3 cycles mid-packet → req_ready[owner]=0 for those cycles; out_packet holds its value; no beat is lost or duplicated; streaming resumes at 1 beat/cycle.
4. Length limit: MAX_BEATS=8, input 1 sends 10 beats with no eop → 8 beats are forwarded, the 8th with bit[0]=1; len_err pulses once; the next grant goes to input 2 if it is requesting; the remaining 2 beats of input 1 are arbitrated as a new packet.
5. Reset mid-packet: drive rst=0 after 2 beats of a 4-beat packet → out_valid=0, busy=0 and req_ready=0 immediately (asynchronous); after release, arbitration starts from input 0.
6. Owner stall: the owner drops req_valid for 5 cycles while inputs 0 and 3 request → grant is held, no other input is accepted, and the owner's packet completes before any switch.
